// File: rtl/usbdev_remote_wake.sv
// rtl/usbdev_remote_wake.sv - device-initiated resume (remote wakeup) K-state generator; optional J tail via USBDEV_WAKE_J_TAIL_EN
module usbdev_remote_wake #(
    parameter int IdleMinUs       = 5000,
    parameter int DriveUs         = 2000,
    parameter int HostTimeoutUs   = 20000,
    // Short DriveUs values are only meaningful for fast simulation runs.
    parameter bit DriveRangeCheck = 1'b1
) (
    input  logic       clk_48mhz_i,
    input  logic       rst_ni,
    input  logic       us_tick_i,
    input  logic       wake_req_i,
    input  logic       link_suspend_i,
    input  logic       link_active_i,
    input  logic       link_disconnect_i,
    input  logic       rx_idle_det_i,
    output logic       wake_oe_o,
    output logic       wake_dp_o,
    output logic       wake_dn_o,
    output logic       wake_busy_o,
    output logic       wake_done_o,
    output logic       wake_abort_o,
    output logic [2:0] wake_state_o
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWaitIdle = 3'd1;
    localparam logic [2:0] StDrive    = 3'd2;
    localparam logic [2:0] StWaitHost = 3'd4;
`ifdef USBDEV_WAKE_J_TAIL_EN
    localparam logic [2:0]  StJTail      = 3'd3;
    localparam logic [2:0]  StAfterDrive = StJTail;
    // One full-speed bit time at 48 MHz is 4 clocks: counts 0..3.
    localparam logic [14:0] JTailLast    = 15'd3;
`else
    localparam logic [2:0]  StAfterDrive = StWaitHost;
`endif

    localparam logic [14:0] IdleMinCnt = 15'(IdleMinUs);
    localparam logic [14:0] DriveCnt   = 15'(DriveUs);
    localparam logic [14:0] HostCnt    = 15'(HostTimeoutUs);

    // A zero or oversized limit would leave a state with no exit.
    if (IdleMinUs < 1 || IdleMinUs > 32767 || DriveUs < 1 || DriveUs > 32767 ||
        HostTimeoutUs < 1 || HostTimeoutUs > 32767) begin : g_param_width_err
        $error("usbdev_remote_wake: timing parameter outside 1..32767");
    end
    if (DriveRangeCheck && (DriveUs < 1000 || DriveUs > 15000)) begin : g_drive_range_err
        $error("usbdev_remote_wake: DriveUs outside 1000..15000");
    end

    logic [2:0]  state_q, state_d;
    logic [14:0] cnt_q, cnt_d, cnt_inc;
    logic        done_q, done_d, abort_q, abort_d;

    // Saturating increment so a missed exit can never wrap back to a small count.
    assign cnt_inc = (cnt_q == 15'h7fff) ? cnt_q : cnt_q + 15'd1;

    // State, counter and completion pulse registers.
    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 15'd0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic; disconnect outranks every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (state_q != StIdle && link_disconnect_i) begin
            state_d = StIdle;
            cnt_d   = 15'd0;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (wake_req_i) begin
                        if (link_suspend_i) begin
                            state_d = StWaitIdle;
                            cnt_d   = 15'd0;
                        end else begin
                            abort_d = 1'b1;
                        end
                    end
                end
                StWaitIdle: begin
                    if (!link_suspend_i) begin
                        state_d = StIdle;
                        cnt_d   = 15'd0;
                        abort_d = 1'b1;
                    end else if (!rx_idle_det_i) begin
                        cnt_d = 15'd0;
                    end else if (us_tick_i) begin
                        if (cnt_inc == IdleMinCnt) begin
                            state_d = StDrive;
                            cnt_d   = 15'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                StDrive: begin
                    if (us_tick_i) begin
                        if (cnt_inc == DriveCnt) begin
                            state_d = StAfterDrive;
                            cnt_d   = 15'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
`ifdef USBDEV_WAKE_J_TAIL_EN
                StJTail: begin
                    if (cnt_q == JTailLast) begin
                        state_d = StWaitHost;
                        cnt_d   = 15'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
                StWaitHost: begin
                    if (link_active_i) begin
                        state_d = StIdle;
                        cnt_d   = 15'd0;
                        done_d  = 1'b1;
                    end else if (us_tick_i) begin
                        if (cnt_inc == HostCnt) begin
                            state_d = StIdle;
                            cnt_d   = 15'd0;
                            abort_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 15'd0;
                end
            endcase
        end
    end

    // PHY drive and status decode from the current state.
    always_comb begin
        wake_oe_o   = 1'b0;
        wake_dp_o   = 1'b1;
        wake_dn_o   = 1'b0;
        wake_busy_o = 1'b0;
        case (state_q)
            StWaitIdle: wake_busy_o = 1'b1;
            StDrive: begin
                wake_busy_o = 1'b1;
                wake_oe_o   = 1'b1;
                wake_dp_o   = 1'b0;
                wake_dn_o   = 1'b1;
            end
`ifdef USBDEV_WAKE_J_TAIL_EN
            StJTail: begin
                wake_busy_o = 1'b1;
                wake_oe_o   = 1'b1;
            end
`endif
            StWaitHost: wake_busy_o = 1'b1;
            default: ;
        endcase
    end

    assign wake_done_o  = done_q;
    assign wake_abort_o = abort_q;
    assign wake_state_o = state_q;

endmodule

// File: tb/tb_usbdev_remote_wake.sv
// tb/tb_usbdev_remote_wake.sv - scoreboard bench for usbdev_remote_wake
module tb_usbdev_remote_wake;

    localparam int TickDiv = 48;
    localparam int IdleMin = 10;
    localparam int DriveN  = 5;
    localparam int HostTo  = 20;
    localparam int NEVER   = 32'h3fff_ffff;
`ifdef USBDEV_WAKE_J_TAIL_EN
    localparam int TailCyc = 4;
`else
    localparam int TailCyc = 0;
`endif

    localparam int EV_K = 0, EV_J = 1, EV_FALL = 2, EV_DONE = 3, EV_ABORT = 4;
    localparam int C_NOSUSP = 0, C_ACT = 1, C_RESTART = 2, C_TIMEOUT = 3,
                   C_EDGE = 4, C_DISC = 5, C_SUSPDROP = 6;

    typedef struct packed { int kind; int at; } ev_t;

    logic       clk_48mhz_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       us_tick_i = 1'b0;
    logic       wake_req_i = 1'b0;
    logic       link_suspend_i = 1'b1;
    logic       link_active_i = 1'b0;
    logic       link_disconnect_i = 1'b0;
    logic       rx_idle_det_i = 1'b1;
    logic       wake_oe_o, wake_dp_o, wake_dn_o, wake_busy_o, wake_done_o, wake_abort_o;
    logic [2:0] wake_state_o;

    int   pe = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    ev_t  expq[$];

    usbdev_remote_wake #(
        .IdleMinUs(IdleMin), .DriveUs(DriveN), .HostTimeoutUs(HostTo), .DriveRangeCheck(1'b0)
    ) dut (
        .clk_48mhz_i(clk_48mhz_i), .rst_ni(rst_ni), .us_tick_i(us_tick_i),
        .wake_req_i(wake_req_i), .link_suspend_i(link_suspend_i),
        .link_active_i(link_active_i), .link_disconnect_i(link_disconnect_i),
        .rx_idle_det_i(rx_idle_det_i), .wake_oe_o(wake_oe_o), .wake_dp_o(wake_dp_o),
        .wake_dn_o(wake_dn_o), .wake_busy_o(wake_busy_o), .wake_done_o(wake_done_o),
        .wake_abort_o(wake_abort_o), .wake_state_o(wake_state_o)
    );

    always #5 clk_48mhz_i = ~clk_48mhz_i;

    always @(posedge clk_48mhz_i) pe <= pe + 1;

    // Tick is sampled on every posedge whose index is a multiple of TickDiv.
    initial begin
        forever begin
            @(negedge clk_48mhz_i);
            us_tick_i = ((pe + 1) % TickDiv == 0);
        end
    end

    function automatic int nth_tick(input int p, input int n);
        return (p / TickDiv + 1) * TickDiv + (n - 1) * TickDiv;
    endfunction

    function automatic string ev_name(input int k);
        case (k)
            EV_K:    return "k_start";
            EV_J:    return "j_start";
            EV_FALL: return "oe_fall";
            EV_DONE: return "done";
            default: return "abort";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int t);
        ev_t e;
        e.kind = k;
        e.at   = t;
        expq.push_back(e);
    endtask

    task automatic got(input int kind);
        ev_t e;
        tests++;
        if (expq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got %s@%0d, expected none", ev_name(kind), pe);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.at != pe) begin
                fails++;
                $display("FAIL event_order: got %s@%0d, expected %s@%0d",
                         ev_name(kind), pe, ev_name(e.kind), e.at);
            end
        end
    endtask

    // Monitor: turns output edges and pulses into events and scores them.
    initial begin
        logic prev_oe, prev_dp;
        prev_oe = 1'b0;
        prev_dp = 1'b1;
        forever begin
            @(negedge clk_48mhz_i);
            if (mon_en) begin
                if (wake_oe_o && !prev_oe) begin
                    got(EV_K);
                    check("k_pins", int'({wake_dp_o, wake_dn_o, wake_state_o, wake_busy_o}), 'h15);
                end
                if (wake_oe_o && prev_oe && wake_dp_o && !prev_dp) begin
                    got(EV_J);
                    check("j_pins", int'({wake_dn_o, wake_state_o}), 3);
                end
                if (!wake_oe_o && prev_oe) begin
                    got(EV_FALL);
                    check("idle_pins", int'({wake_dp_o, wake_dn_o}), 2);
                end
                if (wake_done_o) begin
                    got(EV_DONE);
                    check("done_exit", int'({wake_abort_o, wake_busy_o, wake_state_o}), 0);
                end
                if (wake_abort_o) begin
                    got(EV_ABORT);
                    check("abort_exit", int'({wake_done_o, wake_busy_o, wake_state_o}), 0);
                end
            end
            prev_oe = wake_oe_o;
            prev_dp = wake_dp_o;
        end
    end

    // One wake scenario: predict event times from the rules, then play the inputs.
    task automatic run_case(input int kind, input int fixed);
        int r, q, d, s, x, a, t10, t15, rel, t20, last, p;
        @(negedge clk_48mhz_i);
        r = pe + 2 + int'($urandom_range(0, 60));
        q = NEVER; d = NEVER; s = NEVER; x = NEVER; a = NEVER; last = r;
        if (kind == C_NOSUSP) begin
            s = 0;
            push(EV_ABORT, r);
        end else begin
            t10 = nth_tick(r, IdleMin);
            if (kind == C_RESTART) begin
                d = (fixed > 0) ? nth_tick(r, fixed) : r + 1 + int'($urandom_range(0, t10 - r - 1));
                t10 = nth_tick(d, IdleMin);
            end
            if (kind == C_SUSPDROP) begin
                s = (fixed > 0) ? t10 : r + 1 + int'($urandom_range(0, t10 - r - 1));
                push(EV_ABORT, s);
                last = s;
            end else begin
                push(EV_K, t10);
                t15 = nth_tick(t10, DriveN);
                if (kind == C_DISC) begin
                    x = (fixed > 0) ? nth_tick(t10, 2) : t10 + 1 + int'($urandom_range(0, t15 - t10 - 1));
                    push(EV_FALL, x);
                    push(EV_ABORT, x);
                    last = x;
                end else begin
                    if (TailCyc > 0) push(EV_J, t15);
                    rel = t15 + TailCyc;
                    push(EV_FALL, rel);
                    t20 = nth_tick(rel, HostTo);
                    q = r + 1 + int'($urandom_range(0, rel - r - 1));
                    if (kind == C_ACT)
                        a = (fixed > 0) ? nth_tick(rel, fixed) : rel + 1 + int'($urandom_range(0, 25 * TickDiv));
                    else if (kind == C_EDGE)
                        a = t20 + fixed;
                    if (a <= t20) begin
                        push(EV_DONE, a);
                        last = a;
                    end else begin
                        push(EV_ABORT, t20);
                        last = t20;
                    end
                end
            end
        end
        while (pe < last + 6) begin
            p = pe + 1;
            wake_req_i        = (p == r) || (p == q);
            rx_idle_det_i     = (p != d);
            link_suspend_i    = (p < s);
            link_disconnect_i = (p == x);
            link_active_i     = (p >= a);
            @(negedge clk_48mhz_i);
        end
        wake_req_i = 1'b0; rx_idle_det_i = 1'b1; link_suspend_i = 1'b1;
        link_disconnect_i = 1'b0; link_active_i = 1'b0;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL missing_events: got %0d still pending (first %s@%0d), expected 0",
                     expq.size(), ev_name(expq[0].kind), expq[0].at);
            expq.delete();
        end
    endtask

    initial begin
        int r0, t0;
        repeat (3) @(negedge clk_48mhz_i);
        check("reset_outputs", int'({wake_oe_o, wake_dp_o, wake_dn_o, wake_busy_o,
                                      wake_done_o, wake_abort_o, wake_state_o}), 'h80);
        rst_ni = 1'b1;
        mon_en = 1'b1;

        run_case(C_NOSUSP, 0);
        run_case(C_ACT, 3);
        run_case(C_RESTART, 7);
        run_case(C_TIMEOUT, 0);
        run_case(C_EDGE, 0);
        run_case(C_EDGE, 1);
        run_case(C_DISC, 1);
        run_case(C_ACT, 3);
        run_case(C_SUSPDROP, 1);
        for (int i = 0; i < 10; i++) run_case(int'($urandom_range(0, 6)), 0);

        // Asynchronous reset in the middle of the K drive.
        mon_en = 1'b0;
        @(negedge clk_48mhz_i);
        r0 = pe + 2;
        t0 = nth_tick(r0, IdleMin);
        while (pe < t0 + 20) begin
            wake_req_i = (pe + 1 == r0);
            @(negedge clk_48mhz_i);
        end
        wake_req_i = 1'b0;
        check("drive_before_reset", int'({wake_oe_o, wake_dp_o, wake_dn_o}), 5);
        #2 rst_ni = 1'b0;
        #1 check("async_reset_oe", int'({wake_oe_o, wake_busy_o, wake_state_o}), 0);
        @(negedge clk_48mhz_i);
        rst_ni = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usbdev_remote_wake.md
Name: usbdev_remote_wake

Overview:
- Device-side remote-wakeup signaling generator for usbdev.
- Link-state detection recognises host-driven reset, suspend and resume. This block drives the opposite direction: device-initiated resume, i.e. a K state on D+/D- while the link is suspended.
- It sits beside the link-state logic and feeds the PHY output mux (oe/dp/dn) with priority over the packet transmitter while active.
- It reports completion once the link returns to active, or aborts on timeout or disconnect.

Parameters:
- IdleMinUs, 5000: minimum continuous bus idle (µs) before K may be driven.
- DriveUs, 2000: duration of driven K (µs). Legal range 1000..15000, checked by an elaboration assertion.
- HostTimeoutUs, 20000: after release, maximum wait (µs) for the link to return to active.
- All counters are 15 bits wide. Every parameter must be ≤ 32767.

Ports:
- clk_48mhz_i  in  1  48 MHz clock
- rst_ni  in  1  reset, asynchronous, active-low
- us_tick_i  in  1  one-cycle pulse every 1 µs
- wake_req_i  in  1  software wake request (pulse)
- link_suspend_i  in  1  link in a suspended state (level)
- link_active_i  in  1  link in an active state (level)
- link_disconnect_i  in  1  link disconnected (level)
- rx_idle_det_i  in  1  receiver sees bus idle (level)
- wake_oe_o  out  1  output enable to the PHY mux
- wake_dp_o  out  1  D+ drive value
- wake_dn_o  out  1  D- drive value
- wake_busy_o  out  1  request in progress (level)
- wake_done_o  out  1  wake completed (pulse)
- wake_abort_o  out  1  request rejected or aborted (pulse)
- wake_state_o  out  3  current FSM state encoding

Behaviour:
- Reset values: oe=0, dp=1, dn=0, busy=0, done=0, abort=0, state=Idle (0), counter=0.
- FSM states: Idle=0, WaitIdle=1, Drive=2, JTail=3 (only with the optional feature), WaitHost=4. Codes 5..7 go to Idle.
- busy=1 in every state except Idle.
- oe=1 only in Drive and JTail.
- Drive outputs K: dp=0, dn=1. JTail outputs J: dp=1, dn=0. When oe=0, outputs hold dp=1, dn=0.
- Disconnect priority: link_disconnect_i=1 in any non-Idle state → Idle next cycle, abort pulse for 1 cycle, oe=0 in that next cycle. This overrides every other transition.
- Idle:
  - wake_req_i with link_suspend_i=1 → WaitIdle, counter=0.
  - wake_req_i with link_suspend_i=0 → stay in Idle, abort pulse.
- WaitIdle:
  - rx_idle_det_i=0 → counter=0.
  - Otherwise counter increments on each us_tick_i.
  - Counter reaching IdleMinUs → Drive, counter=0.
  - link_suspend_i falling (host resumed first) → Idle, abort pulse. This takes priority over the Drive transition in the same cycle.
- Drive:
  - oe asserted from the first cycle of Drive. Counter increments on each us_tick_i.
  - The tick that makes counter==DriveUs → WaitHost (or JTail with the feature), counter=0.
  - K therefore spans DriveUs ticks, with +1 tick of latency at entry.
  - link_suspend_i and rx_idle_det_i are ignored, since our own K is visible to the receiver.
- WaitHost:
  - oe=0. Counter increments on each us_tick_i.
  - link_active_i=1 → Idle, done pulse.
  - Counter reaching HostTimeoutUs → Idle, abort pulse.
  - If both occur in the same cycle, done wins.
- wake_req_i while busy: ignored, no pulse.
- done and abort are exactly 1 cycle long and never asserted together.
- Counters saturate rather than wrap: the state always exits on ==.
- Asynchronous reset mid-Drive: oe drops immediately with reset assertion.

Optional Feature:
- Macro: USBDEV_WAKE_J_TAIL_EN.
- Defined: Drive exits to JTail. JTail drives J (oe=1, dp=1, dn=0) for exactly 4 clk cycles (one full-speed bit time), then enters WaitHost. Disconnect priority still applies in JTail.
- Undefined: JTail does not exist, Drive goes directly to WaitHost, and state code 3 maps to Idle.

Test Plan:
- Parameters for all scenarios: IdleMinUs=10, DriveUs=5, HostTimeoutUs=20, us_tick every 48 cycles.
- Nominal wake: suspend=1, idle=1, req pulse → after 10 ticks oe=1, dp=0, dn=1 for 5 ticks, then oe=0. Raise link_active 3 ticks later → done=1 for 1 cycle, busy=0.
- Idle restart: req, then drop rx_idle_det for 1 cycle at tick 7 → Drive entered only 10 ticks after idle returns (17 ticks after req, not 10).
- Not suspended: req with suspend=0 → abort=1 for 1 cycle, state stays 0, oe never asserted.
- Host timeout: complete Drive, hold link_active=0 → abort exactly on the 20th tick after release. Assert link_active together with the 20th tick → done instead of abort.
- Disconnect mid-Drive: assert disconnect at tick 2 of Drive → next cycle oe=0, abort=1, state=0. A later req is serviced normally.
- With USBDEV_WAKE_J_TAIL_EN: after the K, oe=1, dp=1, dn=0 for exactly 4 cycles, state=3, then oe=0, state=4.
